// File: rtl/sfifo_prog.sv
// sfifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a
// synchronous flush. The read mode is selected at elaboration time.
//
// Ports:
//   clk, arst_n       clock and asynchronous active-low reset
//   flush             synchronous clear of pointers and count
//   wren, wdata       write request and data
//   rden, rdata       read request and data (registered or fall-through)
//   af_level/ae_level runtime almost-full / almost-empty thresholds
//   count             current occupancy
//   full, pre_full, almost_full, empty, pre_empty, almost_empty
//                     status flags derived from the registered count only
//   overflow/underflow sticky error flags, cleared by clr_err
module sfifo_prog #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 16,
    parameter int FWFT         = 0,
    parameter int CNT_W        = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flush,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  pre_full,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  pre_empty,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int PTR_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ELEMENTS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_ELEMENTS);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(NUM_ELEMENTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [NUM_ELEMENTS];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  full_s;
    logic                  empty_s;

    // Status flags: functions of the registered count and level inputs only.
    always_comb begin
        full_s       = (count_q == CNT_FULL);
        empty_s      = (count_q == {CNT_W{1'b0}});
        full         = full_s;
        empty        = empty_s;
        pre_full     = (count_q == CNT_PRE);
        pre_empty    = (count_q == CNT_ONE);
        // af_level above the depth can never be reached, so no special case
        almost_full  = (count_q >= af_level);
        almost_empty = (count_q <= ae_level);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Next-state: acceptance, pointer wrap, count, read register, error flags.
    always_comb begin
        wr_acc_s    = wren && !full_s && !flush;
        rd_acc_s    = rden && !empty_s && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // In registered mode this is the output word; in fall-through mode it
        // is the last popped word shown while the FIFO is empty.
        if (rd_acc_s) begin
            rdata_d = mem_q[rd_ptr_q];
        end else begin
            rdata_d = rdata_q;
        end

        // Set has priority over clear.
        if (wren && full_s && !flush) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rden && empty_s && !flush) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Read data mux: fall-through shows the head entry whenever one exists.
    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                if (!empty_s) begin
                    rdata = mem_q[rd_ptr_q];
                end else begin
                    rdata = rdata_q;
                end
            end
        end else begin : g_reg
            always_comb begin
                rdata = rdata_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sfifo_prog.sv
// Testbench for sfifo_prog: one registered-read and one fall-through instance
// share the same stimulus and are compared every cycle against a queue model.
module tb_sfifo_prog;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          arst_n, flush, wren, rden, clr_err;
    logic [DW-1:0] wdata;
    logic [CW-1:0] af_level, ae_level;

    logic          r0_pre_full, r0_full, r0_almost_full, r0_pre_empty, r0_empty, r0_almost_empty;
    logic          r0_overflow, r0_underflow;
    logic [DW-1:0] r0_rdata;
    logic [CW-1:0] r0_count;
    logic          r1_pre_full, r1_full, r1_almost_full, r1_pre_empty, r1_empty, r1_almost_empty;
    logic          r1_overflow, r1_underflow;
    logic [DW-1:0] r1_rdata;
    logic [CW-1:0] r1_count;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd0;
    logic [DW-1:0] m_last;
    bit            m_ovf, m_udf;

    always #5 clk = ~clk;

    sfifo_prog #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .FWFT(0)) u_reg (
        .clk(clk), .arst_n(arst_n), .flush(flush), .wren(wren), .wdata(wdata),
        .pre_full(r0_pre_full), .full(r0_full), .almost_full(r0_almost_full),
        .rden(rden), .rdata(r0_rdata), .pre_empty(r0_pre_empty), .empty(r0_empty),
        .almost_empty(r0_almost_empty), .af_level(af_level), .ae_level(ae_level),
        .count(r0_count), .overflow(r0_overflow), .underflow(r0_underflow), .clr_err(clr_err)
    );

    sfifo_prog #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .FWFT(1)) u_fwft (
        .clk(clk), .arst_n(arst_n), .flush(flush), .wren(wren), .wdata(wdata),
        .pre_full(r1_pre_full), .full(r1_full), .almost_full(r1_almost_full),
        .rden(rden), .rdata(r1_rdata), .pre_empty(r1_pre_empty), .empty(r1_empty),
        .almost_empty(r1_almost_empty), .af_level(af_level), .ae_level(ae_level),
        .count(r1_count), .overflow(r1_overflow), .underflow(r1_underflow), .clr_err(clr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_rd0  = '0;
        m_last = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endfunction

    // One clock edge of the FIFO rules, using the inputs present at the edge.
    function automatic void model_step();
        int            sz;
        logic [DW-1:0] v;
        sz = mq.size();
        if (flush) begin
            mq.delete();
        end else begin
            if (rden && sz > 0) begin
                v = mq.pop_front();
                m_rd0  = v;
                m_last = v;
            end
            if (wren && sz < N) mq.push_back(wdata);
        end
        if (wren && sz == N && !flush) m_ovf = 1'b1;
        else if (clr_err)              m_ovf = 1'b0;
        if (rden && sz == 0 && !flush) m_udf = 1'b1;
        else if (clr_err)              m_udf = 1'b0;
    endfunction

    task automatic cmp_dut(input string t, input logic [CW-1:0] c, input logic pf, input logic f,
                           input logic af, input logic pe, input logic e, input logic ae,
                           input logic ov, input logic ud, input logic [DW-1:0] rd,
                           input logic [DW-1:0] exp_rd);
        int sz;
        sz = mq.size();
        chk({t, ".count"},        32'(c),  32'(sz));
        chk({t, ".pre_full"},     32'(pf), 32'(sz == N - 1));
        chk({t, ".full"},         32'(f),  32'(sz == N));
        chk({t, ".almost_full"},  32'(af), 32'(sz >= int'(af_level)));
        chk({t, ".pre_empty"},    32'(pe), 32'(sz == 1));
        chk({t, ".empty"},        32'(e),  32'(sz == 0));
        chk({t, ".almost_empty"}, 32'(ae), 32'(sz <= int'(ae_level)));
        chk({t, ".overflow"},     32'(ov), 32'(m_ovf));
        chk({t, ".underflow"},    32'(ud), 32'(m_udf));
        chk({t, ".rdata"},        32'(rd), 32'(exp_rd));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en && arst_n) begin
            cmp_dut("reg", r0_count, r0_pre_full, r0_full, r0_almost_full, r0_pre_empty,
                    r0_empty, r0_almost_empty, r0_overflow, r0_underflow, r0_rdata, m_rd0);
            cmp_dut("fwft", r1_count, r1_pre_full, r1_full, r1_almost_full, r1_pre_empty,
                    r1_empty, r1_almost_empty, r1_overflow, r1_underflow, r1_rdata,
                    (mq.size() > 0) ? mq[0] : m_last);
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
        wren    = w;
        wdata   = d;
        rden    = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [DW-1:0] e8;
        arst_n   = 1'b0;
        flush    = 1'b0;
        wren     = 1'b0;
        rden     = 1'b0;
        clr_err  = 1'b0;
        wdata    = '0;
        af_level = 3'd0;
        ae_level = 3'd1;
        model_reset();
        #2;
        // reset state, almost_full follows af_level == 0
        chk("rst.count", 32'(r0_count), 32'd0);
        chk("rst.empty", 32'(r0_empty), 32'd1);
        chk("rst.full", 32'(r0_full), 32'd0);
        chk("rst.pre_empty", 32'(r1_pre_empty), 32'd0);
        chk("rst.almost_empty", 32'(r0_almost_empty), 32'd1);
        chk("rst.af0", 32'(r0_almost_full), 32'd1);
        chk("rst.rdata_fwft", 32'(r1_rdata), 32'd0);
        af_level = 3'd3;
        #1;
        chk("rst.af3", 32'(r0_almost_full), 32'd0);
        #7 arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // fill 0x11..0x44, watch flags at each count
        for (int i = 0; i < 4; i++) begin
            e8 = 8'(8'h11 * (i + 1));
            cyc(1'b1, e8, 1'b0, 1'b0, 1'b0);
            chk("fill.count", 32'(r0_count), 32'(i + 1));
            chk("fill.pre_full", 32'(r0_pre_full), 32'(i == 2));
            chk("fill.full", 32'(r1_full), 32'(i == 3));
            chk("fill.almost_full", 32'(r0_almost_full), 32'(i >= 2));
            chk("fill.almost_empty", 32'(r0_almost_empty), 32'(i == 0));
        end
        chk("fill.fwft_head", 32'(r1_rdata), 32'h11);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("ovf.set", 32'(r0_overflow), 32'd1);
        chk("ovf.count", 32'(r0_count), 32'd4);
        af_level = 3'd5;
        #1;
        chk("af5.drop", 32'(r0_almost_full), 32'd0);
        af_level = 3'd3;
        #1;

        // drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            e8 = 8'(8'h11 * (i + 1));
            chk("drain.reg_rdata", 32'(r0_rdata), 32'(e8));
            e8 = (i < 3) ? 8'(8'h11 * (i + 2)) : 8'h44;
            chk("drain.fwft_rdata", 32'(r1_rdata), 32'(e8));
        end
        chk("drain.empty", 32'(r0_empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("udf.set", 32'(r1_underflow), 32'd1);
        chk("udf.rdata_hold", 32'(r0_rdata), 32'h44);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr.ovf", 32'(r0_overflow), 32'd0);
        chk("clr.udf", 32'(r0_underflow), 32'd0);

        // fall-through first word
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft.first", 32'(r1_rdata), 32'hA5);
        chk("fwft.reg_hold", 32'(r0_rdata), 32'h44);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft.empty", 32'(r1_empty), 32'd1);
        chk("fwft.last", 32'(r1_rdata), 32'hA5);

        // steady-state simultaneous traffic with pointer wrap
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'(i + 3), 1'b1, 1'b0, 1'b0);
            chk("rw.count", 32'(r0_count), 32'd2);
            chk("rw.order", 32'(r0_rdata), 32'(i + 1));
        end
        cyc(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        chk("rw.full", 32'(r0_full), 32'd1);
        cyc(1'b1, 8'h0B, 1'b1, 1'b0, 1'b0);
        chk("fullrw.count", 32'(r0_count), 32'd3);
        chk("fullrw.ovf", 32'(r0_overflow), 32'd1);
        chk("fullrw.rdata", 32'(r0_rdata), 32'h07);
        chk("fullrw.head", 32'(r1_rdata), 32'h08);

        // flush keeps error flags and rdata
        cyc(1'b1, 8'h0C, 1'b0, 1'b1, 1'b0);
        chk("flush.count", 32'(r0_count), 32'd0);
        chk("flush.empty", 32'(r1_empty), 32'd1);
        chk("flush.ovf", 32'(r0_overflow), 32'd1);
        chk("flush.rdata", 32'(r0_rdata), 32'h07);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("flush.clr", 32'(r0_overflow), 32'd0);

        // randomized traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 30;
            if ($urandom_range(0, 99) < 5) af_level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 5) ae_level = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) < wp, 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < (105 - wp), $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 3);
        end

        // asynchronous reset mid-fill
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        wren = 1'b0;
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.count", 32'(r0_count), 32'd0);
        chk("arst.empty", 32'(r0_empty), 32'd1);
        chk("arst.fwft_empty", 32'(r1_empty), 32'd1);
        chk("arst.fwft_rdata", 32'(r1_rdata), 32'd0);
        #10 arst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'(8'h40 + i), i[0], 1'b0, 1'b0);
        end
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sfifo_prog.md
Name:
sfifo_prog

Overview:
Parametrised successor to the team's synchronous FIFO. It is a single-clock buffer with:
- a configurable read mode (registered-read or first-word-fall-through),
- runtime-programmable almost-full and almost-empty thresholds,
- an occupancy count output,
- sticky overflow/underflow error flags,
- a synchronous flush.

It sits between a producer and a consumer in the same clock domain and replaces the basic FIFO where flow control needs early warning or error visibility.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- NUM_ELEMENTS, 16, depth in words. Any integer >= 2; a power of two is not required.
- FWFT, 0, read mode. 0 = registered read; 1 = first-word-fall-through.
- CNT_W, $clog2(NUM_ELEMENTS+1), derived; width of the count and threshold ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wren  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- pre_full  out  1  count == NUM_ELEMENTS-1.
- full  out  1  count == NUM_ELEMENTS.
- almost_full  out  1  count >= af_level.
- rden  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- pre_empty  out  1  count == 1.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= ae_level.
- af_level  in  CNT_W  almost-full threshold.
- ae_level  in  CNT_W  almost-empty threshold.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (arst_n low, asynchronous):
  - pointers = 0, count = 0, rdata = 0, overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, pre_full = 0, pre_empty = 0, almost_empty = 1.
  - almost_full = (af_level == 0).
  - Reset mid-operation discards all contents. Memory contents are not cleared.
- Status flags:
  - All status flags are combinational from the registered count (and the level inputs) only.
  - They never depend on same-cycle wren/rden.
- Write:
  - Accepted iff wren && !full && !flush.
  - wdata is stored at the write pointer. The write pointer advances and wraps from NUM_ELEMENTS-1 to 0.
- Read:
  - Accepted iff rden && !empty && !flush.
  - The read pointer advances with the same wrap rule.
- Count update per cycle:
  - write only: +1; read only: -1; both or neither: unchanged.
  - Simultaneous write and read at count == NUM_ELEMENTS-1 or count == 1 leaves the count and all flags stable.
- Full: a write while full is rejected, even if a read is accepted in the same cycle. No write-through.
- Empty: a read while empty is rejected and rdata holds. No read-through of a same-cycle write.
- Registered read (FWFT = 0):
  - rdata updates on the edge that accepts the read; it is valid the cycle after rden.
  - rdata holds its value otherwise.
- FWFT mode (FWFT = 1):
  - When !empty, rdata presents the head entry combinationally from memory; rden pops it.
  - When empty, rdata shows the last popped word (0 after reset).
  - The first write into an empty FIFO is visible on rdata the cycle after the write edge.
- Errors:
  - overflow sets on wren && full && !flush.
  - underflow sets on rden && empty && !flush.
  - Both clear on clr_err. If set and clear coincide, set wins.
  - flush does not clear the error flags.
- Flush:
  - On the next edge, pointers and count go to 0.
  - flush overrides wren and rden in the same cycle; neither is accepted and neither raises an error.
  - rdata is unchanged by flush.
- Thresholds:
  - af_level and ae_level may change at any time; the flags follow combinationally.
  - af_level > NUM_ELEMENTS means almost_full is never asserted.

Test Plan:
All scenarios use DATA_WIDTH = 8, NUM_ELEMENTS = 4.
1. Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   -> count steps 1, 2, 3, 4; pre_full = 1 at count 3; full = 1 at count 4.
   -> A fifth write of 0x55 sets overflow; count stays 4.
2. FWFT = 0, FIFO holds 0x11..0x44, rden for 4 cycles.
   -> rdata = 0x11, 0x22, 0x33, 0x44, each one cycle after its rden; empty = 1 after the 4th pop.
   -> A further rden sets underflow; rdata stays 0x44.
3. FWFT = 1, write 0xA5 into an empty FIFO.
   -> rdata = 0xA5 the cycle after the write edge, with no rden.
   -> rden for one cycle -> empty = 1; rdata stays 0xA5.
4. Count = 2, wren = rden = 1 for 6 cycles.
   -> count stays 2; pointers wrap; data order is preserved.
   -> At count = 4, wren = rden = 1 -> count becomes 3; the write is rejected and overflow sets.
5. af_level = 3, ae_level = 1, fill from 0 to 4.
   -> almost_empty = 1 at counts 0 and 1; almost_full = 1 at counts 3 and 4.
   -> Changing af_level to 5 with the FIFO full drops almost_full the same cycle.
6. Count = 3, overflow = 1, assert flush with wren = 1.
   -> Next cycle: count = 0, empty = 1, overflow still 1.
   -> clr_err for one cycle -> overflow = 0.
   -> Drop arst_n mid-fill -> count = 0 and empty = 1 immediately, without waiting for a clock edge.
